banked_rob: RTL

Parametrised, multi-bank reorder buffer for the out-of-order core. It sits between rename/dispatch, the writeback network and the commit stage. Each row holds up to BANKS instructions, one dispatch group, in program order. Compared with the previous ROB it supports any bank count, any writeback port count and a pipeline flush. It reports true full/empty, and its operand-readiness lookup resolves to the youngest producer across any number of banks.

---
 rtl/banked_rob.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/banked_rob.sv
// banked_rob: multi-bank reorder buffer, one dispatch group per row.
// Rows allocate at head, retire in order from tail.
module banked_rob #(
    parameter int ROB_SIZE = 16,
    parameter int BANKS    = 2,
    parameter int WB_PORTS = 2,
    parameter int LK_PORTS = 4,
    parameter int PHYS_W   = 6,
    localparam int ROW_W   = $clog2(ROB_SIZE),
    localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [BANKS-1:0]                    disp_en,
    input  logic [BANKS-1:0][PHYS_W-1:0]        disp_phys_rd,
    input  logic [BANKS-1:0][4:0]               disp_arch_rd,
    input  logic [BANKS-1:0][31:0]              disp_pc,
    input  logic [BANKS-1:0][31:0]              disp_instr,
    output logic                                disp_ready,
    output logic [ROW_W-1:0]                    disp_row,
    input  logic [WB_PORTS-1:0]                 wb_en,
    input  logic [WB_PORTS-1:0][ROW_W-1:0]      wb_row,
    input  logic [WB_PORTS-1:0][BANK_W-1:0]     wb_bank,
    input  logic [LK_PORTS-1:0][PHYS_W-1:0]     lk_phys,
    output logic [LK_PORTS-1:0]                 lk_ready,
    output logic [BANKS-1:0]                    commit_en,
    output logic [BANKS-1:0][PHYS_W-1:0]        commit_phys_rd,
    output logic [BANKS-1:0][4:0]               commit_arch_rd,
    output logic [BANKS-1:0][31:0]              commit_pc,
    output logic [BANKS-1:0][31:0]              commit_instr,
    output logic                                empty
);

    typedef struct packed {
        logic [PHYS_W-1:0] phys;
        logic [4:0]        arch;
        logic [31:0]       pc;
        logic [31:0]       instr;
    } payload_t;

    logic [BANKS-1:0] valid_q [ROB_SIZE];
    logic [BANKS-1:0] ready_q [ROB_SIZE];
    payload_t         pay_q   [ROB_SIZE][BANKS];

    logic [ROW_W-1:0] head;
    logic [ROW_W-1:0] tail;
    logic [ROW_W:0]   count;

    logic             disp_fire;
    logic             commit_fire;
    logic [BANKS-1:0] tail_v;
    logic [BANKS-1:0] tail_r;

    assign disp_ready = (count != (ROW_W+1)'(ROB_SIZE));
    assign disp_row   = head;
    assign empty      = (count == '0);

    assign tail_v = valid_q[tail];
    assign tail_r = ready_q[tail];

    assign disp_fire   = (|disp_en) && disp_ready && !flush;
    assign commit_fire = (count != '0) && (|tail_v)
                       && ((tail_v & ~tail_r) == '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < ROB_SIZE; r++) begin
                valid_q[r] <= '0;
                ready_q[r] <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            commit_en <= '0;
            if (rst) begin
                commit_phys_rd <= '0;
                commit_arch_rd <= '0;
                commit_pc      <= '0;
                commit_instr   <= '0;
            end
        end else begin
            if (disp_fire) begin
                valid_q[head] <= disp_en;
                ready_q[head] <= '0;
                for (int b = 0; b < BANKS; b++) begin
                    pay_q[head][b] <= '{disp_phys_rd[b], disp_arch_rd[b],
                                        disp_pc[b], disp_instr[b]};
                end
                head <= head + ROW_W'(1);
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_en[p] && int'(wb_bank[p]) < BANKS
                    && valid_q[wb_row[p]][wb_bank[p]]) begin
                    ready_q[wb_row[p]][wb_bank[p]] <= 1'b1;
                end
            end
            commit_en <= '0;
            if (commit_fire) begin
                commit_en <= tail_v;
                for (int b = 0; b < BANKS; b++) begin
                    commit_phys_rd[b] <= pay_q[tail][b].phys;
                    commit_arch_rd[b] <= pay_q[tail][b].arch;
                    commit_pc[b]      <= pay_q[tail][b].pc;
                    commit_instr[b]   <= pay_q[tail][b].instr;
                end
                valid_q[tail] <= '0;
                ready_q[tail] <= '0;
                tail <= tail + ROW_W'(1);
            end
            unique case (1'b1)
                disp_fire && !commit_fire: count <= count + (ROW_W+1)'(1);
                commit_fire && !disp_fire: count <= count - (ROW_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Walk rows youngest-first, banks high-to-low; first valid match wins.
    always_comb begin
        logic [ROW_W-1:0] r;
        logic             found;
        logic             rdy;
        lk_ready = '1;
        r        = '0;
        found    = 1'b0;
        rdy      = 1'b1;
        for (int k = 0; k < LK_PORTS; k++) begin
            found = 1'b0;
            for (int j = 0; j < ROB_SIZE; j++) begin
                r = head - ROW_W'(j) - ROW_W'(1);
                if (!found && (ROW_W+1)'(j) < count) begin
                    for (int b = BANKS - 1; b >= 0; b--) begin
                        if (!found && valid_q[r][b]
                            && pay_q[r][b].phys == lk_phys[k]) begin
                            found = 1'b1;
                            rdy   = ready_q[r][b];
                            for (int p = 0; p < WB_PORTS; p++) begin
                                if (wb_en[p] && wb_row[p] == r
                                    && int'(wb_bank[p]) == b) begin
                                    rdy = 1'b1;
                                end
                            end
                            lk_ready[k] = rdy;
                        end
                    end
                end
            end
        end
    end

endmodule
